// File: rtl/dds_uart_tx_if.sv
// Parallel byte handshake into the DDS-paced UART transmitter.
interface dds_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dds_uart_tx.sv
// UART transmitter whose bit period is one DDS enable tick; frames are start, data LSB-first,
// optional parity and stop bits. Every output is a register.
module dds_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  dds_uart_tx_if.slave bus,
  output logic         txd,
  output logic         busy,
  output logic         frame_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    PAR   = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic [3:0] DW_C      = 4'(DATA_WIDTH);
  localparam logic [3:0] SB_C      = 4'(STOP_BITS);
  localparam logic       HAS_PAR_C = (PARITY != 0);

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic [3:0]            cnt_r, cnt_s;
  logic                  par_r, par_s;
  logic                  txd_r, txd_s;
  logic                  busy_r, busy_s;
  logic                  ready_r, ready_s;
  logic                  done_r, done_s;
  logic                  accept_s;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  assign accept_s = bus.tx_valid & ready_r;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      shift_r <= '0;
      cnt_r   <= 4'd0;
      par_r   <= 1'b0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
      par_r   <= par_s;
      txd_r   <= txd_s;
      busy_r  <= busy_s;
      ready_r <= ready_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic; a tick in IDLE (even on the accept edge) never advances the frame
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = SYNC;  else state_s = IDLE;
      SYNC:    if (tick)     state_s = START; else state_s = SYNC;
      START:   if (tick)     state_s = DATA;  else state_s = START;
      DATA: begin
        if (tick && (cnt_r >= DW_C)) begin
          state_s = HAS_PAR_C ? PAR : STOP;
        end else begin
          state_s = DATA;
        end
      end
      PAR:     if (tick)     state_s = STOP;  else state_s = PAR;
      STOP: begin
        if (tick && (cnt_r >= SB_C)) begin
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values for line, shifter, shared bit/stop counter and handshake flags
  always_comb begin
    shift_s = shift_r;
    cnt_s   = cnt_r;
    par_s   = par_r;
    txd_s   = txd_r;
    busy_s  = busy_r;
    ready_s = ready_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shift_s = bus.tx_data;
          par_s   = parity_bit(bus.tx_data);
          cnt_s   = 4'd0;
          busy_s  = 1'b1;
          ready_s = 1'b0;
        end else begin
          txd_s = 1'b1;
        end
      end
      SYNC: begin
        if (tick) txd_s = 1'b0; else txd_s = txd_r;
      end
      START: begin
        if (tick) begin
          txd_s   = shift_r[0];
          shift_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
          cnt_s   = 4'd1;
        end else begin
          txd_s = txd_r;
        end
      end
      DATA: begin
        if (tick && (cnt_r < DW_C)) begin
          txd_s   = shift_r[0];
          shift_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
          cnt_s   = cnt_r + 4'd1;
        end else if (tick) begin
          txd_s = HAS_PAR_C ? par_r : 1'b1;
          cnt_s = 4'd1;
        end else begin
          txd_s = txd_r;
        end
      end
      PAR: begin
        if (tick) begin
          txd_s = 1'b1;
          cnt_s = 4'd1;
        end else begin
          txd_s = txd_r;
        end
      end
      STOP: begin
        if (tick && (cnt_r < SB_C)) begin
          cnt_s = cnt_r + 4'd1;
        end else if (tick) begin
          cnt_s   = 4'd0;
          busy_s  = 1'b0;
          ready_s = 1'b1;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        txd_s   = 1'b1;
        busy_s  = 1'b0;
        ready_s = 1'b1;
      end
    endcase
  end

  assign txd          = txd_r;
  assign busy         = busy_r;
  assign frame_done   = done_r;
  assign bus.tx_ready = ready_r;

endmodule

// File: doc/dds_uart_tx.md
Name: dds_uart_tx

Overview:
- UART serial transmitter that sits directly downstream of the DDS fractional-rate counter.
- Consumes its one-cycle `enable` pulse as the bit-time tick: one tick equals one UART bit period.
- Accepts parallel bytes over a valid/ready handshake and serialises them onto a line: start bit, data LSB-first, optional parity, stop bit(s).
- Baud rate is set entirely by the DDS ADD/MAX ratio; this block contains no divider.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bit periods (1 or 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset. Assertion (0) clears state immediately; release is sampled on clk.
- tick  input  1  bit-time strobe from the DDS counter `enable`; single-cycle pulses, arbitrary spacing.
- tx_data  input  DATA_WIDTH  byte to send; sampled on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept; accept = tx_valid & tx_ready on a clk edge.
- txd  output  1  serial line, idle high.
- busy  output  1  high from accept until the frame's last stop bit period ends.
- frame_done  output  1  one-cycle pulse on the clk edge that ends the last stop bit.

Behaviour:
- Reset values: txd=1, tx_ready=1, busy=0, frame_done=0, state IDLE, bit counter 0, shift register 0.
- States: IDLE, SYNC, START, DATA, PAR, STOP.
- IDLE:
  - tx_ready=1.
  - On accept: latch tx_data into the shift register, compute parity, set busy=1, tx_ready=0, go to SYNC.
  - A tick in IDLE is ignored.
- SYNC: wait for tick. On tick: txd<=0, go to START. This aligns the start bit to the DDS phase.
- START: on tick: txd<=shift[0], shift right, bit counter=1, go to DATA.
- DATA: on each tick:
  - If bit counter < DATA_WIDTH: txd<=shift[0], shift right, counter+1.
  - Else, with PARITY != 0: txd<=parity bit, go to PAR.
  - Else, with PARITY = 0: txd<=1, stop counter=1, go to STOP.
- PAR: on tick: txd<=1, stop counter=1, go to STOP.
- STOP:
  - On tick with stop counter < STOP_BITS: counter+1, txd stays 1.
  - On tick with stop counter = STOP_BITS: go to IDLE, busy<=0, tx_ready<=1, frame_done pulses for that one cycle.
- Parity:
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
  - Computed at accept from the latched data.
- Timing:
  - Every txd level holds exactly one tick-to-tick interval. The first level (start bit) begins at the first tick strictly after the accept edge.
  - A tick coincident with the accept edge does not start the frame.
- Back-to-back frames:
  - The next accept can occur at the earliest one clk after frame_done. Its start bit begins at the following tick.
  - With tick spacing >= 2 clk, frames are gapless on the line.
  - With tick every clk (ADD==MAX), one extra idle bit period is inserted per frame. This is required behaviour, not a defect.
- tx_valid held while busy: ignored; no data is latched.
- tx_data changing after accept: no effect on the frame in flight.
- tick stuck high: advances one state/bit per clk; legal.
- Reset mid-frame: txd returns high immediately (asynchronous), frame abandoned, no frame_done.
- Frame length in ticks = 1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS.

Test Plan:
- Defaults, tick every 4 clk, send 0xA5 -> txd after accept, one level per tick: 0,1,0,1,0,0,1,0,1,1. frame_done fires exactly 10 ticks after the start bit begins. busy is 1 throughout.
- PARITY=2, send 0x07 -> 11-tick frame; parity bit 1. PARITY=1, same data -> parity bit 0.
- STOP_BITS=2, tx_valid held high, send 0x00 then 0xFF, tick every 3 clk -> stop level lasts 2 ticks. The second start bit falls on the tick immediately after frame_done, with no idle gap.
- Tick every clk, two queued bytes -> exactly one extra idle-high bit period between frames.
- Assert rst low during DATA bit 3 -> txd=1 and tx_ready=1 without a clk edge. No frame_done. After release, a new byte transmits correctly.
- Tick coincident with the accept edge -> start bit begins at the next tick, not that one. Changing tx_data and pulsing tx_valid mid-frame -> line output unchanged.
